mac_frame_to_axis_bridge: RTL and testbench

- Frame-aware buffer between the MAC-side receive stream (data/valid/end-of-frame, no backpressure) and an AXI4-Stream master that feeds the MicroBlaze RXD stream FIFO.
- Replaces direct wiring, which ignores tready. Only complete frames are presented downstream.
- Frames that overflow the buffer, or that are shorter than MIN_WORDS, are discarded whole and counted.
- Parametrised in data width, depth and counter width.

---
 rtl/mac_frame_to_axis_bridge.sv | 176 +++++++++++++++++
 tb/tb_mac_frame_to_axis_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_to_axis_bridge.sv
// mac_frame_to_axis_bridge
//
// Frame-aware buffer between a MAC receive stream (no backpressure) and an
// AXI4-Stream master. Words are written speculatively and become visible
// downstream only when the frame's last word has been stored. A frame is
// discarded whole if it overflows the buffer or is shorter than MIN_WORDS.
//
// Ports:
//   clk_83          sole clock, rising edge
//   reset_n         asynchronous active-low reset (synchronised release)
//   data_in         MAC receive word
//   data_valid_in   data_in valid this cycle
//   end_of_frame_in last word of frame (qualified by data_valid_in)
//   m_axis_tdata    output word
//   m_axis_tvalid   output word valid
//   m_axis_tlast    last word of the frame
//   m_axis_tready   downstream accept
//   stat_clr        synchronous clear of both statistics counters
//   frames_passed   committed frames, saturating
//   frames_dropped  overflow and runt drops, saturating
//   fill_level      committed, unread words
module mac_frame_to_axis_bridge #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int MIN_WORDS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_83,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_valid_in,
  input  logic                     end_of_frame_in,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         frames_passed,
  output logic [CNT_W-1:0]         frames_dropped,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_DROP   = 1'b1;

  // Reset asserts asynchronously but is released through two flops so all
  // state leaves reset on the same clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk_83 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  logic [DATA_W:0]  mem [DEPTH];
  logic [PW-1:0]    wr_ptr, cm_ptr, rd_ptr, frame_len;
  logic [PW-1:0]    wr_next, cm_next, rd_next, len_next;
  logic [0:0]       state, state_next;
  logic             wr_en, pass_inc, drop_inc, pop, full;
  logic [PW-1:0]    used;
  logic [31:0]      len_plus1;
  logic [DATA_W:0]  rd_word;

  // Full is judged on the registered read pointer: a pop in this cycle does
  // not make room for this cycle's write.
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == DEPTH_P);
  assign len_plus1 = 32'(frame_len) + 32'd1;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;

  // Write side: speculative write, then commit or roll back at end of frame.
  always_comb begin
    wr_en      = 1'b0;
    wr_next    = wr_ptr;
    cm_next    = cm_ptr;
    len_next   = frame_len;
    state_next = state;
    pass_inc   = 1'b0;
    drop_inc   = 1'b0;
    if (data_valid_in) begin
      if (state == ST_ACCEPT) begin
        if (!full) begin
          wr_en    = 1'b1;
          wr_next  = wr_ptr + PW'(1);
          len_next = frame_len + PW'(1);
          if (end_of_frame_in) begin
            len_next = '0;
            if (len_plus1 >= 32'(MIN_WORDS)) begin
              cm_next  = wr_ptr + PW'(1);
              pass_inc = 1'b1;
            end else begin
              wr_next  = cm_ptr;
              drop_inc = 1'b1;
            end
          end
        end else begin
          // Overflow: discard the partial frame; skip its tail unless this
          // beat already ends it.
          wr_next  = cm_ptr;
          len_next = '0;
          drop_inc = 1'b1;
          if (!end_of_frame_in) begin
            state_next = ST_DROP;
          end
        end
      end else if (end_of_frame_in) begin
        state_next = ST_ACCEPT;
      end
    end
  end

  // Storage has no reset; only pointer-covered words are ever read.
  always_ff @(posedge clk_83) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {end_of_frame_in, data_in};
    end
  end

  // Pointers, FSM, and the registered status derived from the next pointers.
  always_ff @(posedge clk_83 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr        <= '0;
      cm_ptr        <= '0;
      rd_ptr        <= '0;
      frame_len     <= '0;
      state         <= ST_ACCEPT;
      m_axis_tvalid <= 1'b0;
      fill_level    <= '0;
    end else begin
      wr_ptr        <= wr_next;
      cm_ptr        <= cm_next;
      rd_ptr        <= rd_next;
      frame_len     <= len_next;
      state         <= state_next;
      m_axis_tvalid <= (rd_next != cm_next);
      fill_level    <= cm_next - rd_next;
    end
  end

  // Saturating statistics; a clear overrides a coincident increment.
  always_ff @(posedge clk_83 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frames_passed  <= '0;
      frames_dropped <= '0;
    end else if (stat_clr) begin
      frames_passed  <= '0;
      frames_dropped <= '0;
    end else begin
      if (pass_inc && (frames_passed != CNT_MAX)) begin
        frames_passed <= frames_passed + CNT_W'(1);
      end
      if (drop_inc && (frames_dropped != CNT_MAX)) begin
        frames_dropped <= frames_dropped + CNT_W'(1);
      end
    end
  end

  // First-word-fall-through read. The slot at rd_ptr cannot be overwritten
  // while it holds unread data, so the output stays stable during a stall.
  assign rd_word      = mem[rd_ptr[AW-1:0]];
  assign m_axis_tdata = m_axis_tvalid ? rd_word[DATA_W-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & rd_word[DATA_W];

endmodule

// File: tb/tb_mac_frame_to_axis_bridge.sv
// tb_mac_frame_to_axis_bridge
//
// Self-checking bench for mac_frame_to_axis_bridge (DEPTH=16, MIN_WORDS=3,
// CNT_W=4). A frame-level reference model tracks buffer occupancy in words,
// pending and committed frames as queues, and the saturating counters.
// Committed words are pushed into a scoreboard queue; a negedge monitor pops
// and compares them on every handshake.
module tb_mac_frame_to_axis_bridge;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int MIN_WORDS = 3;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                   clk_83 = 1'b0;
  logic                   reset_n = 1'b1;
  logic [DATA_W-1:0]      data_in = '0;
  logic                   data_valid_in = 1'b0;
  logic                   end_of_frame_in = 1'b0;
  logic [DATA_W-1:0]      m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tlast;
  logic                   m_axis_tready = 1'b0;
  logic                   stat_clr = 1'b0;
  logic [CNT_W-1:0]       frames_passed;
  logic [CNT_W-1:0]       frames_dropped;
  logic [$clog2(DEPTH):0] fill_level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] pend_q[$];
  int m_occ = 0;
  int m_committed = 0;
  int m_passed = 0;
  int m_dropped = 0;
  bit m_drop_mode = 1'b0;

  // 0 = tready low, 1 = high, 2 = toggle, 3 = random
  int ready_mode = 0;
  int hs_count = 0;
  int tl_count = 0;
  bit hold_valid = 1'b0;
  logic [DATA_W:0] hold_word = '0;
  logic [DATA_W:0] sb_word;

  mac_frame_to_axis_bridge #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_WORDS(MIN_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk_83(clk_83),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_valid_in(data_valid_in),
    .end_of_frame_in(end_of_frame_in),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .stat_clr(stat_clr),
    .frames_passed(frames_passed),
    .frames_dropped(frames_dropped),
    .fill_level(fill_level)
  );

  always #6 clk_83 = ~clk_83;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void modelReset();
    exp_q.delete();
    pend_q.delete();
    m_occ       = 0;
    m_committed = 0;
    m_passed    = 0;
    m_dropped   = 0;
    m_drop_mode = 1'b0;
  endfunction

  // One clock of the frame-level model, using the values present before the edge.
  function automatic void modelStep();
    bit pop, full, pinc, dinc;
    pop  = (m_committed > 0) && m_axis_tready;
    full = (m_occ == DEPTH);
    pinc = 1'b0;
    dinc = 1'b0;
    if (data_valid_in) begin
      if (m_drop_mode) begin
        if (end_of_frame_in) m_drop_mode = 1'b0;
      end else if (full) begin
        m_occ -= pend_q.size();
        pend_q.delete();
        dinc = 1'b1;
        if (!end_of_frame_in) m_drop_mode = 1'b1;
      end else begin
        pend_q.push_back({end_of_frame_in, data_in});
        m_occ++;
        if (end_of_frame_in) begin
          if (pend_q.size() >= MIN_WORDS) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            m_committed += pend_q.size();
            pinc = 1'b1;
          end else begin
            m_occ -= pend_q.size();
            dinc = 1'b1;
          end
          pend_q.delete();
        end
      end
    end
    if (pop) begin
      m_committed--;
      m_occ--;
    end
    if (stat_clr) begin
      m_passed  = 0;
      m_dropped = 0;
    end else begin
      if (pinc && m_passed < CNT_MAX) m_passed++;
      if (dinc && m_dropped < CNT_MAX) m_dropped++;
    end
  endfunction

  // Model advances on each rising edge.
  always @(posedge clk_83) begin
    if (!reset_n) modelReset();
    else modelStep();
  end

  // Downstream ready pattern, driven just after the edge.
  always @(posedge clk_83) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: status against the model, output beats against the scoreboard.
  always @(negedge clk_83) begin
    checkOutput("tvalid", m_axis_tvalid, (m_committed > 0));
    checkOutput("fill_level", fill_level, m_committed);
    checkOutput("frames_passed", frames_passed, m_passed);
    checkOutput("frames_dropped", frames_dropped, m_dropped);
    if (hold_valid && m_axis_tvalid) begin
      checkOutput("stall_tdata", m_axis_tdata, hold_word[DATA_W-1:0]);
      checkOutput("stall_tlast", m_axis_tlast, hold_word[DATA_W]);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      hs_count++;
      if (m_axis_tlast) tl_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=0x%0h required=no beat", m_axis_tdata);
      end else begin
        sb_word = exp_q.pop_front();
        checkOutput("tdata", m_axis_tdata, sb_word[DATA_W-1:0]);
        checkOutput("tlast", m_axis_tlast, sb_word[DATA_W]);
      end
    end
    hold_valid = m_axis_tvalid && !m_axis_tready;
    hold_word  = {m_axis_tlast, m_axis_tdata};
  end

  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit e, input bit clr);
    data_valid_in   = v;
    data_in         = d;
    end_of_frame_in = e;
    stat_clr        = clr;
    @(posedge clk_83);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input int len, input logic [DATA_W-1:0] base, input bit clr_on_eof);
    for (int i = 0; i < len; i++) begin
      applyStimulus(1'b1, base + DATA_W'(i), (i == len - 1), clr_on_eof && (i == len - 1));
    end
    data_valid_in   = 1'b0;
    end_of_frame_in = 1'b0;
    stat_clr        = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_committed != 0) && n < 400) begin
      @(posedge clk_83);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain timeout actual=%0d words left required=0", name, exp_q.size());
    end
  endtask

  task automatic doReset();
    reset_n         = 1'b0;
    modelReset();
    data_valid_in   = 1'b0;
    end_of_frame_in = 1'b0;
    stat_clr        = 1'b0;
    #1;
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_fill", fill_level, 0);
    checkOutput("rst_passed", frames_passed, 0);
    checkOutput("rst_dropped", frames_dropped, 0);
    repeat (3) @(posedge clk_83);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk_83);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs0, tl0, gap, len;

    #1;
    doReset();
    checkOutput("post_release_tvalid", m_axis_tvalid, 0);

    // Single 4-word frame, tready high
    ready_mode = 1;
    idle(2);
    sendFrame(4, 32'hA0, 1'b0);
    checkOutput("t1_latency_tvalid", m_axis_tvalid, 1);
    checkOutput("t1_first_word", m_axis_tdata, 32'hA0);
    waitDrain("t1");
    idle(2);
    checkOutput("t1_fill_zero", fill_level, 0);
    checkOutput("t1_passed", frames_passed, 1);

    // Full buffer: 16-word frame stalls, 3-word frame overflows on its first word
    ready_mode = 0;
    idle(2);
    sendFrame(16, 32'h100, 1'b0);
    sendFrame(3, 32'h200, 1'b0);
    idle(1);
    checkOutput("t2_fill_full", fill_level, 16);
    checkOutput("t2_dropped", frames_dropped, 1);
    hs0 = hs_count;
    tl0 = tl_count;
    ready_mode = 1;
    waitDrain("t2");
    idle(2);
    checkOutput("t2_beats", hs_count - hs0, 16);
    checkOutput("t2_tlasts", tl_count - tl0, 1);

    // Oversized frame is dropped and its tail skipped; next frame intact
    sendFrame(20, 32'h300, 1'b0);
    idle(1);
    checkOutput("t3_dropped", frames_dropped, 2);
    sendFrame(3, 32'h400, 1'b0);
    waitDrain("t3");
    idle(2);
    checkOutput("t3_passed", frames_passed, 3);

    // Runt filter
    sendFrame(1, 32'h500, 1'b0);
    sendFrame(2, 32'h510, 1'b0);
    sendFrame(3, 32'h520, 1'b0);
    waitDrain("t4");
    idle(2);
    checkOutput("t4_dropped", frames_dropped, 4);
    checkOutput("t4_passed", frames_passed, 4);

    // Toggling tready
    ready_mode = 2;
    idle(2);
    hs0 = hs_count;
    sendFrame(8, 32'h600, 1'b0);
    waitDrain("t5");
    idle(2);
    checkOutput("t5_beats", hs_count - hs0, 8);

    // Counter clear, clear-vs-increment, saturation
    ready_mode = 1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t6_clr_passed", frames_passed, 0);
    sendFrame(3, 32'h700, 1'b0);
    sendFrame(3, 32'h710, 1'b0);
    idle(1);
    checkOutput("t6_two_passed", frames_passed, 2);
    sendFrame(3, 32'h720, 1'b1);
    checkOutput("t6_clr_wins", frames_passed, 0);
    for (int f = 0; f < 17; f++) sendFrame(3, 32'h1000 + 32'(f * 16), 1'b0);
    for (int f = 0; f < 17; f++) sendFrame(1, 32'h2000 + 32'(f), 1'b0);
    waitDrain("t6");
    idle(2);
    checkOutput("t6_passed_sat", frames_passed, CNT_MAX);
    checkOutput("t6_dropped_sat", frames_dropped, CNT_MAX);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Randomised frames, gaps, backpressure and occasional clears
    ready_mode = 3;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        applyStimulus(1'b1, $urandom(), (i == len - 1),
                      (i == len - 1) && ($urandom_range(0, 9) == 0));
      end
      gap = $urandom_range(0, 3);
      idle(gap);
    end
    ready_mode = 1;
    waitDrain("t7");
    idle(2);

    // Reset with a committed frame stalled and a partial frame in flight
    ready_mode = 0;
    idle(2);
    sendFrame(5, 32'h900, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h910 + 32'(i), 1'b0, 1'b0);
    checkOutput("t8_pre_reset_tvalid", m_axis_tvalid, 1);
    doReset();
    ready_mode = 1;
    idle(2);
    sendFrame(3, 32'h920, 1'b0);
    waitDrain("t8");
    idle(2);
    checkOutput("t8_passed", frames_passed, 1);
    checkOutput("t8_fill_zero", fill_level, 0);

    checkOutput("end_scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
